text_buffer: RTL and testbench
==============================

// Module: text_buffer
// PURPOSE
//   Character buffer feeding the text renderer. Stores a COLS x ROWS grid of
//   7-bit ASCII codes, accepts a byte stream (e.g. UART rx) with a valid/ready
//   handshake, and maintains a write cursor with wrap, newline, backspace and
//   clear-screen. Per pixel it maps (x,y) to a cell and returns ascii_char.
// PARAMETERS
//   COLS  32   characters per row (8 px wide each); power of 2
//   ROWS  4    character rows (16 px tall each); power of 2
//   X0    192  left pixel of text region
//   Y0    208  top pixel of text region
// PORTS
//   clk         in   1     system clock
//   reset       in   1     asynchronous, active-high reset
//   wr_valid    in   1     wr_data valid
//   wr_data     in   8     byte to print or control code
//   wr_ready    out  1     buffer can accept a byte this cycle
//   x           in   10    current pixel column
//   y           in   10    current pixel row
//   ascii_char  out  7     character code at (x,y), registered
//   cursor_col  out  $clog2(COLS)  next write column
//   cursor_row  out  $clog2(ROWS)  next write row
// BEHAVIOUR
//   Reset values: state=CLEAR, clr_idx=0, cursor 0/0, wr_ready=0, ascii_char=7'h20.
//   FSM states:
//     CLEAR: write 7'h20 to cell clr_idx, clr_idx++. Takes exactly COLS*ROWS
//            cycles, then goes to IDLE. wr_ready=0.
//     IDLE:  wr_ready=1. A byte is accepted when wr_valid && wr_ready.
//            One byte is accepted per cycle with no bubbles.
//   Accepted byte handling (the cursor update is visible on the next cycle):
//     0x20..0x7E: write wr_data[6:0] at the cursor, then col++.
//                 col==COLS-1 -> col=0, row++. row==ROWS-1 -> row=0.
//                 No scrolling; old text is overwritten.
//     0x0A/0x0D:  col=0, row++ (wraps as above). No cell write.
//     0x08:       col>0 -> col--. col==0 && row>0 -> col=COLS-1, row--.
//                 Then write 0x20 at the new cursor position.
//                 At 0/0 there is no effect.
//     0x0C:       cursor=0/0, clr_idx=0, go to CLEAR.
//     Any other code, or bit7=1: accepted and ignored.
//   Read path:
//     col = (x-X0)>>3 and row = (y-Y0)>>4, computed from the 10-bit difference.
//     A position is inside the region when X0<=x<X0+8*COLS and Y0<=y<Y0+16*ROWS.
//     ascii_char is registered with 1-cycle latency: it reflects x,y sampled on
//     the previous edge. Outside the region it is 0x20.
//     While in CLEAR, ascii_char=0x20 regardless of position.
//     If a read and a write hit the same cell in the same cycle, the read
//     returns the old value (read-before-write).
//   Reset asserted mid-operation (mid-CLEAR or mid-stream): FSM restarts CLEAR
//     from clr_idx=0. Memory contents are undefined until that CLEAR completes.
//   Storage is a single inferred sync RAM of COLS*ROWS x 7.
//     Address = {row,col}; the write port is muxed between the clear FSM and
//     the stream.
// TESTING
//   1. Release reset -> wr_ready=0 for exactly 128 cycles, then 1. A full-frame
//      scan of the region returns 0x20 everywhere.
//   2. Send 0x41 -> cursor_col=1. With x=192, y=208, ascii_char=0x41 one cycle
//      later. x=199 gives the same; x=200 gives 0x20.
//   3. Stream 32 printable bytes -> cursor 0/1. 128 bytes -> cursor 0/0.
//      The 129th byte (0x5A) overwrites cell 0/0 and reads back 0x5A.
//   4. Cursor at 0/1, send 0x08 -> cursor 31/0 and cell 31/0=0x20.
//      Send 0x08 at 0/0 -> cursor and memory unchanged.
//   5. Mid-stream 0x0C -> wr_ready=0 for 128 cycles, ascii_char=0x20 throughout,
//      cursor 0/0. Assert reset at cycle 50 of CLEAR -> a full 128-cycle CLEAR
//      restarts.
//   6. Out-of-region reads (x=191, x=448, y=207, y=272) -> 0x20. A same-cycle
//      write and read of one cell -> old value, new value on the next read.
//      Hold wr_valid with wr_ready=0 -> byte consumed only once ready rises.

Source files
------------

// File: rtl/text_buffer_if.sv
// Byte-stream write channel into the text buffer.
//   wr_valid  producer -> buffer  wr_data holds a byte this cycle
//   wr_data   producer -> buffer  printable ASCII or control code
//   wr_ready  buffer -> producer  buffer accepts a byte this cycle
interface text_buffer_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_buffer.sv
// Character grid (COLS x ROWS of 7-bit ASCII) for the text renderer.
// Accepts a byte stream with a write cursor (wrap, newline, backspace,
// clear-screen) and returns the character under pixel (x,y) one cycle later.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr                    byte stream in (valid/ready handshake)
//   x, y                  current pixel position
//   ascii_char            character at the previous cycle's (x,y); 0x20 outside
//                         the text region or while clearing
//   cursor_col/cursor_row next write position
module text_buffer #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 4,
    parameter int unsigned X0   = 192,
    parameter int unsigned Y0   = 208,
    localparam int unsigned COL_W = $clog2(COLS),
    localparam int unsigned ROW_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    text_buffer_if.slave      wr,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [6:0]        ascii_char,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row
);

    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned CELL_W = $clog2(CELLS);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state, state_next;
    logic [CELL_W-1:0]   clr_idx, clr_next;
    logic [COL_W-1:0]    col_next;
    logic [ROW_W-1:0]    row_next;
    logic                ready, ready_next;
    logic                accept;
    logic                we;
    logic [CELL_W-1:0]   waddr;
    logic [6:0]          wdata;

    logic [6:0]          mem [CELLS];

    logic [9:0]          dx, dy;
    logic                in_region;
    logic [CELL_W-1:0]   raddr;

    assign wr.wr_ready = ready;

    // State, clear index, cursor and ready registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            ready      <= 1'b0;
        end else begin
            state      <= state_next;
            clr_idx    <= clr_next;
            cursor_col <= col_next;
            cursor_row <= row_next;
            ready      <= ready_next;
        end
    end

    // Next state, cursor update and write-port mux (clear sweep vs stream)
    always_comb begin
        state_next = state;
        clr_next   = clr_idx;
        col_next   = cursor_col;
        row_next   = cursor_row;
        ready_next = 1'b0;
        we         = 1'b0;
        waddr      = {cursor_row, cursor_col};
        wdata      = 7'h20;
        accept     = wr.wr_valid && ready;

        unique case (state)
            CLEAR: begin
                we       = 1'b1;
                waddr    = clr_idx;
                clr_next = clr_idx + CELL_W'(1);
                if (clr_idx == CELL_W'(CELLS - 1)) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                end
            end
            IDLE: begin
                ready_next = 1'b1;
                if (accept) begin
                    if (wr.wr_data >= 8'h20 && wr.wr_data <= 8'h7E) begin
                        we    = 1'b1;
                        wdata = wr.wr_data[6:0];
                        // Row wraps naturally since ROWS is a power of 2
                        if (cursor_col == COL_W'(COLS - 1)) begin
                            col_next = '0;
                            row_next = cursor_row + ROW_W'(1);
                        end else begin
                            col_next = cursor_col + COL_W'(1);
                        end
                    end else if (wr.wr_data == 8'h0A || wr.wr_data == 8'h0D) begin
                        col_next = '0;
                        row_next = cursor_row + ROW_W'(1);
                    end else if (wr.wr_data == 8'h08) begin
                        // Blank the cell at the new cursor; no-op at 0/0
                        if (cursor_col != '0) begin
                            col_next = cursor_col - COL_W'(1);
                            we       = 1'b1;
                            waddr    = {cursor_row, col_next};
                        end else if (cursor_row != '0) begin
                            col_next = COL_W'(COLS - 1);
                            row_next = cursor_row - ROW_W'(1);
                            we       = 1'b1;
                            waddr    = {row_next, col_next};
                        end
                    end else if (wr.wr_data == 8'h0C) begin
                        col_next   = '0;
                        row_next   = '0;
                        clr_next   = '0;
                        state_next = CLEAR;
                        ready_next = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Character RAM write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Pixel -> cell mapping; the difference compare also rejects x<X0/y<Y0 wrap
    assign dx        = x - 10'(X0);
    assign dy        = y - 10'(Y0);
    assign in_region = (x >= 10'(X0)) && (dx < 10'(8 * COLS)) &&
                       (y >= 10'(Y0)) && (dy < 10'(16 * ROWS));
    assign raddr     = {dy[4 +: ROW_W], dx[3 +: COL_W]};

    // Registered read; same-cycle write to this cell returns the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ascii_char <= 7'h20;
        end else if (state == CLEAR || !in_region) begin
            ascii_char <= 7'h20;
        end else begin
            ascii_char <= mem[raddr];
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: reset/clear timing, printing, wrap,
// backspace, newline, ignored codes, read region bounds, read-before-write,
// clear-screen with held input, and reset during clear.
module tb_text_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic [6:0] ascii_char;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;

    text_buffer_if bus();

    text_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (bus),
        .x          (x),
        .y          (y),
        .ascii_char (ascii_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected character pattern used for the fill streams
    function automatic logic [6:0] chr(input int k);
        return 7'(65 + k % 26);
    endfunction

    function automatic logic [6:0] chr_lc(input int k);
        return 7'(97 + k % 26);
    endfunction

    // All tasks start and end just after a falling edge
    task automatic send(input logic [7:0] b);
        int n;
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_xy(input int px, input int py, output logic [6:0] v);
        x = 10'(px);
        y = 10'(py);
        @(negedge clk);
        v = ascii_char;
    endtask

    task automatic check_cell(input string tag, input int col, input int row, input logic [6:0] exp);
        logic [6:0] v;
        read_xy(192 + 8 * col, 208 + 16 * row, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic check_xy(input string tag, input int px, input int py, input logic [6:0] exp);
        logic [6:0] v;
        read_xy(px, py, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cursor_col), 32'(col));
        check({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    // Counts cycles until wr_ready rises; also counts non-blank reads meanwhile
    task automatic wait_clear(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (bus.wr_ready !== 1'b1 && n < 1000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (ascii_char !== 7'h20) bad++;
        end
    endtask

    task automatic scan_all(input string tag);
        logic [6:0] v;
        int bad;
        bad = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 32; c++) begin
                read_xy(192 + 8 * c, 208 + 16 * r, v);
                if (v !== 7'h20) bad++;
            end
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n, bad;
        logic [6:0] v;

        x = '0;
        y = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_ascii", 32'(ascii_char), 32'h20);
        check_cursor("rst_cursor", 0, 0);

        // 1. Initial clear length and blank frame
        reset = 1'b0;
        wait_clear(n, bad);
        check("init_clear_len", 32'(n), 32'd128);
        scan_all("init_scan");

        // 2. Single character and cell pixel bounds
        send(8'h41);
        check_cursor("a_cursor", 1, 0);
        check_xy("a_x192", 192, 208, 7'h41);
        check_xy("a_x199", 199, 208, 7'h41);
        check_xy("a_x200", 200, 208, 7'h20);

        // 3. Fill: end of row 0, then whole buffer wraps to 0/0
        for (int k = 1; k < 32; k++) send({1'b0, chr(k)});
        check_cursor("row_wrap", 0, 1);
        for (int k = 32; k < 128; k++) send({1'b0, chr(k)});
        check_cursor("frame_wrap", 0, 0);
        check_cell("cell_31_0", 31, 0, chr(31));
        check_cell("cell_0_1", 0, 1, chr(32));
        check_cell("cell_31_3", 31, 3, chr(127));
        send(8'h5A);
        check_cell("overwrite_0_0", 0, 0, 7'h5A);
        check_cursor("overwrite_cursor", 1, 0);

        // Ignored codes: bit7 set and an unused control code
        send(8'hC1);
        send(8'h07);
        check_cursor("ignored_cursor", 1, 0);
        check_cell("ignored_cell", 1, 0, chr_lc(0) == 7'h00 ? 7'h00 : chr(1));

        // 4. Backspace across a row boundary
        for (int k = 1; k < 32; k++) send({1'b0, chr_lc(k)});
        check_cursor("lc_wrap", 0, 1);
        send(8'h08);
        check_cursor("bs_wrap", 31, 0);
        check_cell("bs_blank", 31, 0, 7'h20);
        check_cell("bs_keep", 30, 0, chr_lc(30));
        // Newlines from 31/0 walk rows 1,2,3 then wrap to 0
        send(8'h0A);
        check_cursor("nl_1", 0, 1);
        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        check_cursor("nl_wrap", 0, 0);
        send(8'h08);
        check_cursor("bs_origin", 0, 0);
        check_cell("bs_origin_0_0", 0, 0, 7'h5A);
        check_cell("bs_origin_31_3", 31, 3, chr(127));

        // 6. Out-of-region reads, and in-region corner
        check_xy("out_x191", 191, 208, 7'h20);
        check_xy("out_x448", 448, 208, 7'h20);
        check_xy("out_y207", 192, 207, 7'h20);
        check_xy("out_y272", 192, 272, 7'h20);
        check_xy("in_corner", 447, 271, chr(127));

        // Same-cycle read and write of cell 0/0
        x = 10'd192;
        y = 10'd208;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h51;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("rbw_old", 32'(ascii_char), 32'h5A);
        @(negedge clk);
        check("rbw_new", 32'(ascii_char), 32'h51);
        check_cursor("rbw_cursor", 1, 0);

        // 5. Clear-screen mid-stream with a byte held during clear
        send(8'h0C);
        check_cursor("cls_cursor", 0, 0);
        check("cls_ready", 32'(bus.wr_ready), 32'd0);
        x = 10'd192;
        y = 10'd208;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h43;
        wait_clear(n, bad);
        check("cls_len", 32'(n), 32'd128);
        check("cls_blank_reads", 32'(bad), 32'd0);
        check_cursor("hold_before", 0, 0);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check_cursor("hold_once", 1, 0);
        check_cell("hold_cell0", 0, 0, 7'h43);
        check_cell("hold_cell1", 1, 0, 7'h20);
        check_cell("cls_cell_31_3", 31, 3, 7'h20);

        // Reset asserted 50 cycles into a clear restarts it from the beginning
        send(8'h0C);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.wr_ready), 32'd0);
        check("mid_rst_ascii", 32'(ascii_char), 32'h20);
        check_cursor("mid_rst_cursor", 0, 0);
        reset = 1'b0;
        wait_clear(n, bad);
        check("mid_rst_clear_len", 32'(n), 32'd128);
        scan_all("mid_rst_scan");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
